// File: rtl/key_debounce.sv
// Push-button front end: per-key 2-FF synchroniser, debounce FSM and optional
// auto-repeat, producing clean press/release pulses and a debounced level.

module key_debounce_chan #(
  parameter int CNT_W        = 20,
  parameter int RPT_W        = 25,
  parameter int DEBOUNCE_CYC = 500000,
  parameter bit REPEAT_EN    = 1'b0,
  parameter int REPEAT_DLY   = 25000000,
  parameter int REPEAT_PER   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  output logic press,
  output logic rel_pulse,
  output logic level
);

  typedef enum logic [1:0] {REL, REL_P, HELD, HELD_P} state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_DLY - 1);
  localparam logic [RPT_W-1:0] RPT_LOAD = RPT_W'(REPEAT_DLY - REPEAT_PER);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [RPT_W-1:0] rpt, rpt_n;
  logic             press_n, rel_n, level_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= REL;
      cnt       <= '0;
      rpt       <= '0;
      press     <= 1'b0;
      rel_pulse <= 1'b0;
      level     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rpt       <= rpt_n;
      press     <= press_n;
      rel_pulse <= rel_n;
      level     <= level_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rpt_n   = rpt;
    press_n = 1'b0;
    rel_n   = 1'b0;
    level_n = level;
    case (state)
      REL: begin
        if (s) begin
          state_n = REL_P;
          cnt_n   = CNT_W'(1);
        end
      end
      REL_P: begin
        if (!s) begin
          state_n = REL;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n = HELD;
          cnt_n   = '0;
          rpt_n   = '0;
          press_n = 1'b1;
          level_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_n = HELD_P;
          cnt_n   = CNT_W'(1);
        end else if (REPEAT_EN) begin
          // Reloading DLY-PER spaces later repeats PER apart after the first.
          if (rpt == RPT_LAST) begin
            press_n = 1'b1;
            rpt_n   = RPT_LOAD;
          end else if (rpt != '1) begin
            rpt_n = rpt + 1'b1;
          end
        end
      end
      HELD_P: begin
        // Repeat timer is frozen here and resumes if the key bounces back.
        if (s) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n = REL;
          cnt_n   = '0;
          rel_n   = 1'b1;
          level_n = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = REL;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

module key_debounce #(
  parameter int NKEYS        = 9,
  parameter int CNT_W        = 20,
  parameter int DEBOUNCE_CYC = 500000,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter bit REPEAT_EN    = 1'b0,
  parameter int REPEAT_DLY   = 25000000,
  parameter int REPEAT_PER   = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] key_raw,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic [NKEYS-1:0] key_level
);

  // Repeat delay can exceed the debounce counter range, so widen as needed.
  localparam int RPT_NEED = $clog2(REPEAT_DLY + 1);
  localparam int RPT_W    = (RPT_NEED > CNT_W) ? RPT_NEED : CNT_W;
  localparam logic [NKEYS-1:0] IDLE = ACTIVE_LOW ? {NKEYS{1'b1}} : {NKEYS{1'b0}};

  logic [NKEYS-1:0] sync1, sync2, s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  assign s = sync2 ^ IDLE;

  for (genvar g = 0; g < NKEYS; g++) begin : g_chan
    key_debounce_chan #(
      .CNT_W       (CNT_W),
      .RPT_W       (RPT_W),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .REPEAT_EN   (REPEAT_EN),
      .REPEAT_DLY  (REPEAT_DLY),
      .REPEAT_PER  (REPEAT_PER)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .s        (s[g]),
      .press    (key_press[g]),
      .rel_pulse(key_release[g]),
      .level    (key_level[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: one instance without and one with
// auto-repeat, fed the same raw pins; edges counted from the first posedge.

module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] key_raw;
  logic [8:0] press0, rel0, lvl0, press1, rel1, lvl1;
  int n_chk  = 0;
  int n_fail = 0;
  int ec     = 0;

  always #5 clk = ~clk;

  key_debounce #(
    .NKEYS(9), .CNT_W(20), .DEBOUNCE_CYC(4), .ACTIVE_LOW(1'b1),
    .REPEAT_EN(1'b0), .REPEAT_DLY(10), .REPEAT_PER(3)
  ) dut_norpt (
    .clk(clk), .rst(rst), .key_raw(key_raw),
    .key_press(press0), .key_release(rel0), .key_level(lvl0)
  );

  key_debounce #(
    .NKEYS(9), .CNT_W(20), .DEBOUNCE_CYC(4), .ACTIVE_LOW(1'b1),
    .REPEAT_EN(1'b1), .REPEAT_DLY(10), .REPEAT_PER(3)
  ) dut_rpt (
    .clk(clk), .rst(rst), .key_raw(key_raw),
    .key_press(press1), .key_release(rel1), .key_level(lvl1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    ec++;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s edge %0d: got %h expected %h", tag, ec, obs, exp);
    end
  endtask

  task automatic chk_all(input logic [8:0] ep0, input logic [8:0] er0, input logic [8:0] el0,
                         input logic [8:0] ep1, input logic [8:0] er1, input logic [8:0] el1);
    chk("press_norpt", press0, ep0);
    chk("release_norpt", rel0, er0);
    chk("level_norpt", lvl0, el0);
    chk("press_rpt", press1, ep1);
    chk("release_rpt", rel1, er1);
    chk("level_rpt", lvl1, el1);
  endtask

  initial begin
    logic [8:0] ep0, er0, el0, ep1;

    // Reset with key 0 already pressed: nothing may come out.
    key_raw = 9'h1FE;
    rst     = 1'b1;
    repeat (3) begin
      tick();
      chk_all('0, '0, '0, '0, '0, '0);
    end
    rst     = 1'b0;
    key_raw = 9'h1FF;
    while (ec < 10) begin
      tick();
      chk_all('0, '0, '0, '0, '0, '0);
    end

    // Key 0 press/hold/release, key 1 bounce then long hold.
    key_raw[0] = 1'b0;
    while (ec < 70) begin
      tick();
      ep0 = '0; er0 = '0; el0 = '0;
      ep0[0] = (ec == 16);
      ep0[1] = (ec == 29);
      el0[0] = (ec >= 16 && ec < 42);
      el0[1] = (ec >= 29 && ec < 65);
      er0[0] = (ec == 42);
      er0[1] = (ec == 65);
      ep1    = ep0;
      ep1[0] = (ec == 16) || (ec >= 26 && ec <= 38 && (ec - 26) % 3 == 0);
      ep1[1] = (ec == 29) || (ec >= 39 && ec <= 60 && (ec - 39) % 3 == 0);
      chk_all(ep0, er0, el0, ep1, er0, el0);
      case (ec)
        20: key_raw[1] = 1'b0;
        22: key_raw[1] = 1'b1;
        23: key_raw[1] = 1'b0;
        36: key_raw[0] = 1'b1;
        59: key_raw[1] = 1'b1;
        default: ;
      endcase
    end

    while (ec < 72) begin
      tick();
      chk_all('0, '0, '0, '0, '0, '0);
    end

    // Keys 0 and 8 together, first try.
    key_raw = 9'h0FE;
    while (ec < 90) begin
      tick();
      ep0 = (ec == 78) ? 9'h101 : 9'h000;
      el0 = (ec >= 78 && ec < 86) ? 9'h101 : 9'h000;
      er0 = (ec == 86) ? 9'h101 : 9'h000;
      chk_all(ep0, er0, el0, ep0, er0, el0);
      if (ec == 80) key_raw = 9'h1FF;
    end

    while (ec < 92) begin
      tick();
      chk_all('0, '0, '0, '0, '0, '0);
    end

    // Second try, reset pulsed mid-debounce (sampled at edge 96).
    key_raw = 9'h0FE;
    while (ec < 104) begin
      tick();
      ep0 = (ec == 102) ? 9'h101 : 9'h000;
      el0 = (ec >= 102) ? 9'h101 : 9'h000;
      chk_all(ep0, '0, el0, ep0, '0, el0);
      if (ec == 95) rst = 1'b1;
      if (ec == 96) rst = 1'b0;
    end

    key_raw = 9'h1FF;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
